lfsr_prbs_checker: RTL and testbench
====================================

Name: lfsr_prbs_checker

Overview:
- Receive-side counterpart of the 22-bit LFSR pattern generator.
- Takes a serial bit stream with a valid strobe, self-synchronises a local LFSR to it, then checks every later bit against the local prediction.
- Reports lock status, per-bit error pulses and a saturating error count. These drive LEDs or the 7-seg display during loopback tests on the Go Board.

Parameters:
- NUM_BITS, 22, LFSR length. Taps are fixed at bits NUM_BITS-1 and NUM_BITS-2, XNOR feedback.
- WINDOW_BITS, 64, number of valid bits per loss-of-lock evaluation window.
- LOSS_ERRORS, 8, error count within one window that forces resync.
- CNT_WIDTH, 16, width of the error counter.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Data  in  1  received serial bit; sampled only when i_Valid=1.
- i_Valid  in  1  qualifies i_Data; any duty cycle is allowed, including back-to-back.
- i_Clear  in  1  synchronous clear of o_Error_Count only.
- o_Locked  out  1  1 while in state LOCKED.
- o_Bit_Error  out  1  one-cycle pulse per mismatched bit while LOCKED.
- o_Error_Count  out  CNT_WIDTH  saturating count of mismatches since reset or clear.

Behaviour:
- Reset:
  - state=SYNC; shift register, sync counter, window counter and window error counter all 0.
  - o_Locked=0, o_Bit_Error=0, o_Error_Count=0.
  - A reset mid-operation has the same effect on the next edge.
- Shift convention: r <= {r[NUM_BITS-2:0], b}. Prediction p = ~(r[NUM_BITS-1] ^ r[NUM_BITS-2]).
- SYNC:
  - Each valid bit shifts i_Data into r and increments sync_cnt.
  - When the NUM_BITS-th valid bit is taken:
    - if the resulting r is all-ones (the XNOR lockup state), set sync_cnt=0 and stay in SYNC;
    - otherwise go to LOCKED and clear the window counters.
  - No errors are reported in SYNC.
- LOCKED:
  - Each valid bit compares i_Data with p, then shifts p, never i_Data, into r, so one bad bit causes exactly one error.
  - Mismatch:
    - o_Bit_Error=1 on the cycle after the i_Valid cycle; otherwise 0.
    - o_Error_Count increments and holds at all-ones with no wrap.
    - the window error counter increments.
  - win_cnt counts valid bits. On the WINDOW_BITS-th bit:
    - if win_err, including the current bit, is >= LOSS_ERRORS: go to SYNC, set sync_cnt=0 and o_Locked=0 on the next cycle;
    - else clear win_cnt and win_err and stay LOCKED.
  - The LOSS_ERRORS check also happens immediately on any bit that brings win_err to LOSS_ERRORS; early exit is allowed and required.
- o_Locked rises on the cycle after the final sync bit is accepted.
- i_Valid=0 cycles: no state change; o_Bit_Error=0.
- i_Clear:
  - zeroes o_Error_Count only.
  - if a mismatch occurs in the same cycle, the result is 1 (clear, then count).
- The bit count in this spec covers the data bits only; no per-bit latency beyond one register.

Decomposition:
- Shared package holds:
  - LFSR tap constants for NUM_BITS=22;
  - the state encoding, SYNC=1'b0 and LOCKED=1'b1;
  - the XNOR-feedback function, also used by the generator.
- One natural sub-module: lfsr_predictor, which holds r and supports load-shift and predict-shift modes. Counters and the state machine stay in the top.

Test Plan:
1. Reset, then 22 valid bits from the generator seeded at 0 → o_Locked=1 one cycle after bit 22; 1000 further bits give o_Error_Count=0.
2. While locked, invert bit 100 of the stream → exactly one o_Bit_Error pulse one cycle later; o_Error_Count=1; o_Locked stays 1.
3. While locked, feed random data for 64 bits → o_Locked drops once win_err reaches 8; after 22 correct generator bits, relock.
4. 22 valid bits of all 1s → o_Locked stays 0 and sync restarts; then a correct stream locks within 22 bits.
5. Preload o_Error_Count near max, force 70,000 errors with LOSS_ERRORS large → count holds at 16'hFFFF; i_Clear with a simultaneous error → 1.
6. i_Valid toggling 1-of-3 cycles with a correct stream, then i_Reset asserted mid-lock → all outputs 0 next edge; relock after 22 valid bits.

Source files
------------

// File: rtl/lfsr_prbs_checker_pkg.sv
// Shared definitions for the 22-bit XNOR PRBS generator/checker pair.
package lfsr_prbs_checker_pkg;

    localparam int unsigned LFSR_BITS = 22;
    localparam int unsigned TAP_HI    = LFSR_BITS - 1;
    localparam int unsigned TAP_LO    = LFSR_BITS - 2;

    typedef enum logic {
        StSync   = 1'b0,
        StLocked = 1'b1
    } state_e;

    // Next bit of the sequence; all-ones is the lockup state for XNOR feedback.
    function automatic logic xnor_feedback(input logic tap_hi, input logic tap_lo);
        return ~(tap_hi ^ tap_lo);
    endfunction

endpackage

// File: rtl/lfsr_prbs_checker_if.sv
// Serial stream in, lock/error status out.
interface lfsr_prbs_checker_if #(
    parameter int unsigned CNT_WIDTH = 16
);

    logic                 i_Data;
    logic                 i_Valid;
    logic                 i_Clear;
    logic                 o_Locked;
    logic                 o_Bit_Error;
    logic [CNT_WIDTH-1:0] o_Error_Count;

    modport master (
        output i_Data, i_Valid, i_Clear,
        input  o_Locked, o_Bit_Error, o_Error_Count
    );

    modport slave (
        input  i_Data, i_Valid, i_Clear,
        output o_Locked, o_Bit_Error, o_Error_Count
    );

endinterface

// File: rtl/lfsr_predictor.sv
// Local copy of the generator LFSR: loads received bits while syncing,
// free-runs on its own prediction once locked.
module lfsr_predictor
    import lfsr_prbs_checker_pkg::*;
#(
    parameter int unsigned NUM_BITS = LFSR_BITS
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Shift,
    input  logic i_Load,
    input  logic i_Data,
    output logic o_Predict,
    output logic o_Load_All_Ones
);

    logic [NUM_BITS-1:0] r_lfsr;
    logic [NUM_BITS-1:0] w_load_value;
    logic                w_predict;

    // Prediction and the value a load-shift would produce.
    always_comb begin
        w_predict    = xnor_feedback(r_lfsr[NUM_BITS-1], r_lfsr[NUM_BITS-2]);
        w_load_value = {r_lfsr[NUM_BITS-2:0], i_Data};
    end

    // Shift register: received bit in load mode, own prediction otherwise.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_lfsr <= '0;
        end else if (i_Shift) begin
            r_lfsr <= i_Load ? w_load_value : {r_lfsr[NUM_BITS-2:0], w_predict};
        end
    end

    assign o_Predict       = w_predict;
    assign o_Load_All_Ones = &w_load_value;

endmodule

// File: rtl/lfsr_prbs_checker.sv
// PRBS receive checker: self-syncs to the stream, then flags every bit that
// disagrees with the local prediction and drops lock on bursts of errors.
module lfsr_prbs_checker
    import lfsr_prbs_checker_pkg::*;
#(
    parameter int unsigned NUM_BITS    = LFSR_BITS,
    parameter int unsigned WINDOW_BITS = 64,
    parameter int unsigned LOSS_ERRORS = 8,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input logic                i_Clk,
    input logic                i_Reset,
    lfsr_prbs_checker_if.slave bus
);

    localparam int unsigned SYNC_W = $clog2(NUM_BITS);
    localparam int unsigned WIN_W  = $clog2(WINDOW_BITS);
    localparam int unsigned WERR_W = $clog2(WINDOW_BITS + 1);

    state_e               r_state, w_state_next;
    logic [SYNC_W-1:0]    r_sync_cnt, w_sync_next;
    logic [WIN_W-1:0]     r_win_cnt, w_win_cnt_next;
    logic [WERR_W-1:0]    r_win_err, w_win_err_next;
    logic [WERR_W-1:0]    w_win_err_sum;
    logic                 r_bit_error;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic                 w_predict;
    logic                 w_load_ones;
    logic                 w_mismatch;
    logic                 w_loss;

    lfsr_predictor #(
        .NUM_BITS (NUM_BITS)
    ) u_predictor (
        .i_Clk           (i_Clk),
        .i_Reset         (i_Reset),
        .i_Shift         (bus.i_Valid),
        .i_Load          (r_state == StSync),
        .i_Data          (bus.i_Data),
        .o_Predict       (w_predict),
        .o_Load_All_Ones (w_load_ones)
    );

    // Mismatch detection and window error tally including the current bit.
    always_comb begin
        w_mismatch    = bus.i_Valid && (r_state == StLocked) && (bus.i_Data != w_predict);
        w_win_err_sum = r_win_err + WERR_W'(w_mismatch);
        w_loss        = 32'(w_win_err_sum) >= LOSS_ERRORS;
    end

    // Next-state logic for sync/lock and the two window counters.
    always_comb begin
        w_state_next   = r_state;
        w_sync_next    = r_sync_cnt;
        w_win_cnt_next = r_win_cnt;
        w_win_err_next = r_win_err;
        unique case (r_state)
            StSync: begin
                if (bus.i_Valid) begin
                    if (r_sync_cnt == SYNC_W'(NUM_BITS - 1)) begin
                        w_sync_next = '0;
                        // An all-ones load would never advance; retry the sync.
                        if (!w_load_ones) begin
                            w_state_next   = StLocked;
                            w_win_cnt_next = '0;
                            w_win_err_next = '0;
                        end
                    end else begin
                        w_sync_next = r_sync_cnt + SYNC_W'(1);
                    end
                end
            end
            StLocked: begin
                if (bus.i_Valid) begin
                    w_win_err_next = w_win_err_sum;
                    if (w_loss) begin
                        w_state_next = StSync;
                        w_sync_next  = '0;
                    end else if (r_win_cnt == WIN_W'(WINDOW_BITS - 1)) begin
                        w_win_cnt_next = '0;
                        w_win_err_next = '0;
                    end else begin
                        w_win_cnt_next = r_win_cnt + WIN_W'(1);
                    end
                end
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= StSync;
            r_sync_cnt <= '0;
            r_win_cnt  <= '0;
            r_win_err  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_sync_cnt <= w_sync_next;
            r_win_cnt  <= w_win_cnt_next;
            r_win_err  <= w_win_err_next;
        end
    end

    // Error pulse and saturating error count; clear takes effect before counting.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_bit_error <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_bit_error <= w_mismatch;
            if (bus.i_Clear) begin
                r_err_cnt <= CNT_WIDTH'(w_mismatch);
            end else if (w_mismatch && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_Locked      = (r_state == StLocked);
    assign bus.o_Bit_Error   = r_bit_error;
    assign bus.o_Error_Count = r_err_cnt;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: instance A uses default parameters, instance B
// never loses lock so its counter can be driven into saturation.
module tb_lfsr_prbs_checker;

    typedef struct packed {
        logic        locked;
        logic        bit_err;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_prbs_checker_if #(.CNT_WIDTH(16)) bus_a ();
    lfsr_prbs_checker_if #(.CNT_WIDTH(16)) bus_b ();

    lfsr_prbs_checker #(
        .NUM_BITS(22), .WINDOW_BITS(64), .LOSS_ERRORS(8), .CNT_WIDTH(16)
    ) u_dut_a (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus_a.slave)
    );

    lfsr_prbs_checker #(
        .NUM_BITS(22), .WINDOW_BITS(64), .LOSS_ERRORS(65), .CNT_WIDTH(16)
    ) u_dut_b (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus_b.slave)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_e;

    // Reference model of instance A, written from the behavioural description.
    logic        m_locked = 1'b0;
    logic [21:0] m_reg    = '0;
    int          m_sync   = 0;
    int          m_wcnt   = 0;
    int          m_werr   = 0;
    int          m_cnt    = 0;
    logic        m_err    = 1'b0;

    logic [21:0] gen_a;
    logic [21:0] gen_b;

    // Scoreboard: each driven cycle queued one expectation, checked after the edge.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            mon_e = q_a.pop_front();
            total++;
            if (bus_a.o_Locked !== mon_e.locked) begin
                bad++;
                $display("FAIL sb_a_locked t=%0t got=%0b exp=%0b", $time, bus_a.o_Locked, mon_e.locked);
            end
            total++;
            if (bus_a.o_Bit_Error !== mon_e.bit_err) begin
                bad++;
                $display("FAIL sb_a_bit_error t=%0t got=%0b exp=%0b", $time, bus_a.o_Bit_Error,
                         mon_e.bit_err);
            end
            total++;
            if (bus_a.o_Error_Count !== mon_e.cnt) begin
                bad++;
                $display("FAIL sb_a_count t=%0t got=%0d exp=%0d", $time, bus_a.o_Error_Count, mon_e.cnt);
            end
        end
        if (q_b.size() > 0) begin
            mon_e = q_b.pop_front();
            total++;
            if (bus_b.o_Locked !== mon_e.locked) begin
                bad++;
                $display("FAIL sb_b_locked t=%0t got=%0b exp=%0b", $time, bus_b.o_Locked, mon_e.locked);
            end
            total++;
            if (bus_b.o_Bit_Error !== mon_e.bit_err) begin
                bad++;
                $display("FAIL sb_b_bit_error t=%0t got=%0b exp=%0b", $time, bus_b.o_Bit_Error,
                         mon_e.bit_err);
            end
            total++;
            if (bus_b.o_Error_Count !== mon_e.cnt) begin
                bad++;
                $display("FAIL sb_b_count t=%0t got=%0d exp=%0d", $time, bus_b.o_Error_Count, mon_e.cnt);
            end
        end
    end

    task automatic gen_step(inout logic [21:0] g, output logic b);
        b = ~(g[21] ^ g[20]);
        g = {g[20:0], b};
    endtask

    task automatic model_step(input logic d, input logic v, input logic clr, input logic rs);
        logic p;
        m_err = 1'b0;
        if (rs) begin
            m_locked = 1'b0;
            m_reg    = '0;
            m_sync   = 0;
            m_wcnt   = 0;
            m_werr   = 0;
            m_cnt    = 0;
        end else begin
            if (v && !m_locked) begin
                m_reg = {m_reg[20:0], d};
                m_sync++;
                if (m_sync == 22) begin
                    m_sync = 0;
                    if (m_reg != 22'h3FFFFF) begin
                        m_locked = 1'b1;
                        m_wcnt   = 0;
                        m_werr   = 0;
                    end
                end
            end else if (v) begin
                p     = ~(m_reg[21] ^ m_reg[20]);
                m_reg = {m_reg[20:0], p};
                m_err = (d != p);
                if (m_err) m_werr++;
                m_wcnt++;
                if (m_werr >= 8) begin
                    m_locked = 1'b0;
                    m_sync   = 0;
                end else if (m_wcnt == 64) begin
                    m_wcnt = 0;
                    m_werr = 0;
                end
            end
            if (clr) m_cnt = m_err ? 1 : 0;
            else if (m_err && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic drive_a(input logic d, input logic v, input logic clr, input logic rs);
        exp_t e;
        bus_a.i_Data  = d;
        bus_a.i_Valid = v;
        bus_a.i_Clear = clr;
        rst           = rs;
        model_step(d, v, clr, rs);
        e.locked  = m_locked;
        e.bit_err = m_err;
        e.cnt     = 16'(m_cnt);
        q_a.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic drive_b(input logic d, input logic v, input logic clr, input logic rs,
                           input exp_t e);
        bus_b.i_Data  = d;
        bus_b.i_Valid = v;
        bus_b.i_Clear = clr;
        rst           = rs;
        q_b.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        drive_a(1'b1, 1'b1, 1'b0, 1'b1);
        drive_a(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (bus_a.o_Locked !== 1'b0) begin
            bad++; $display("FAIL reset_locked got=%0b exp=0", bus_a.o_Locked);
        end
        total++;
        if (bus_a.o_Bit_Error !== 1'b0) begin
            bad++; $display("FAIL reset_bit_error got=%0b exp=0", bus_a.o_Bit_Error);
        end
        total++;
        if (bus_a.o_Error_Count !== 16'd0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", bus_a.o_Error_Count);
        end
    endtask

    task automatic test_lock();
        logic b;
        gen_a = '0;
        for (int i = 0; i < 22; i++) begin
            gen_step(gen_a, b);
            drive_a(b, 1'b1, 1'b0, 1'b0);
            if (i == 20) begin
                total++;
                if (bus_a.o_Locked !== 1'b0) begin
                    bad++; $display("FAIL lock_early got=%0b exp=0", bus_a.o_Locked);
                end
            end
        end
        total++;
        if (bus_a.o_Locked !== 1'b1) begin
            bad++; $display("FAIL lock_after_22 got=%0b exp=1", bus_a.o_Locked);
        end
        for (int i = 0; i < 1000; i++) begin
            gen_step(gen_a, b);
            drive_a(b, 1'b1, 1'b0, 1'b0);
        end
        total++;
        if (bus_a.o_Error_Count !== 16'd0) begin
            bad++; $display("FAIL clean_count got=%0d exp=0", bus_a.o_Error_Count);
        end
    endtask

    task automatic test_single_error();
        logic b;
        int   pulses = 0;
        for (int i = 0; i < 120; i++) begin
            gen_step(gen_a, b);
            drive_a((i == 99) ? ~b : b, 1'b1, 1'b0, 1'b0);
            if (bus_a.o_Bit_Error === 1'b1) pulses++;
            if (i == 99) begin
                total++;
                if (bus_a.o_Bit_Error !== 1'b1) begin
                    bad++; $display("FAIL single_pulse_timing got=%0b exp=1", bus_a.o_Bit_Error);
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL single_pulse_count got=%0d exp=1", pulses);
        end
        total++;
        if (bus_a.o_Error_Count !== 16'd1) begin
            bad++; $display("FAIL single_count got=%0d exp=1", bus_a.o_Error_Count);
        end
        total++;
        if (bus_a.o_Locked !== 1'b1) begin
            bad++; $display("FAIL single_stay_locked got=%0b exp=1", bus_a.o_Locked);
        end
    endtask

    task automatic test_loss();
        logic        b;
        logic        dropped = 1'b0;
        logic [15:0] cnt_hold;
        for (int i = 0; i < 64 && !dropped; i++) begin
            drive_a(logic'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            if (bus_a.o_Locked === 1'b0) begin
                dropped = 1'b1;
                total++;
                if (bus_a.o_Bit_Error !== 1'b1) begin
                    bad++; $display("FAIL loss_on_error got=%0b exp=1", bus_a.o_Bit_Error);
                end
            end
        end
        total++;
        if (dropped !== 1'b1) begin
            bad++; $display("FAIL loss_dropped got=%0b exp=1", dropped);
        end
        cnt_hold = bus_a.o_Error_Count;
        for (int i = 0; i < 22; i++) begin
            gen_step(gen_a, b);
            drive_a(b, 1'b1, 1'b0, 1'b0);
            if (i == 20) begin
                total++;
                if (bus_a.o_Locked !== 1'b0) begin
                    bad++; $display("FAIL relock_early got=%0b exp=0", bus_a.o_Locked);
                end
            end
        end
        total++;
        if (bus_a.o_Locked !== 1'b1) begin
            bad++; $display("FAIL relock got=%0b exp=1", bus_a.o_Locked);
        end
        for (int i = 0; i < 100; i++) begin
            gen_step(gen_a, b);
            drive_a(b, 1'b1, 1'b0, 1'b0);
        end
        total++;
        if (bus_a.o_Error_Count !== cnt_hold) begin
            bad++; $display("FAIL relock_count got=%0d exp=%0d", bus_a.o_Error_Count, cnt_hold);
        end
    endtask

    task automatic test_lockup();
        logic b;
        drive_a(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 22; i++) drive_a(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (bus_a.o_Locked !== 1'b0) begin
            bad++; $display("FAIL lockup_no_lock got=%0b exp=0", bus_a.o_Locked);
        end
        gen_a = '0;
        for (int i = 0; i < 22; i++) begin
            gen_step(gen_a, b);
            drive_a(b, 1'b1, 1'b0, 1'b0);
            if (i == 20) begin
                total++;
                if (bus_a.o_Locked !== 1'b0) begin
                    bad++; $display("FAIL lockup_resync_early got=%0b exp=0", bus_a.o_Locked);
                end
            end
        end
        total++;
        if (bus_a.o_Locked !== 1'b1) begin
            bad++; $display("FAIL lockup_resync got=%0b exp=1", bus_a.o_Locked);
        end
        for (int i = 0; i < 50; i++) begin
            gen_step(gen_a, b);
            drive_a(b, 1'b1, 1'b0, 1'b0);
        end
        total++;
        if (bus_a.o_Error_Count !== 16'd0) begin
            bad++; $display("FAIL lockup_count got=%0d exp=0", bus_a.o_Error_Count);
        end
    endtask

    task automatic test_back_to_back();
        logic b;
        for (int i = 0; i < 60; i++) begin
            gen_step(gen_a, b);
            drive_a((i == 30) ? ~b : b, 1'b1, 1'b0, 1'b0);
            drive_a(logic'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            drive_a(logic'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        total++;
        if (bus_a.o_Error_Count !== 16'd1) begin
            bad++; $display("FAIL sparse_count got=%0d exp=1", bus_a.o_Error_Count);
        end
        // Reset lands together with a bad valid bit.
        gen_step(gen_a, b);
        drive_a(~b, 1'b1, 1'b0, 1'b1);
        total++;
        if (bus_a.o_Locked !== 1'b0) begin
            bad++; $display("FAIL midreset_locked got=%0b exp=0", bus_a.o_Locked);
        end
        total++;
        if (bus_a.o_Bit_Error !== 1'b0) begin
            bad++; $display("FAIL midreset_bit_error got=%0b exp=0", bus_a.o_Bit_Error);
        end
        total++;
        if (bus_a.o_Error_Count !== 16'd0) begin
            bad++; $display("FAIL midreset_count got=%0d exp=0", bus_a.o_Error_Count);
        end
        gen_a = '0;
        for (int i = 0; i < 22; i++) begin
            gen_step(gen_a, b);
            drive_a(b, 1'b1, 1'b0, 1'b0);
            if (i == 21) begin
                total++;
                if (bus_a.o_Locked !== 1'b1) begin
                    bad++; $display("FAIL sparse_relock got=%0b exp=1", bus_a.o_Locked);
                end
            end
            drive_a(1'b0, 1'b0, 1'b0, 1'b0);
            drive_a(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 20) begin
                total++;
                if (bus_a.o_Locked !== 1'b0) begin
                    bad++; $display("FAIL sparse_relock_early got=%0b exp=0", bus_a.o_Locked);
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic b;
        int   n;
        drive_b(1'b0, 1'b0, 1'b0, 1'b1, '{locked: 1'b0, bit_err: 1'b0, cnt: 16'd0});
        gen_b = '0;
        for (int i = 0; i < 22; i++) begin
            gen_step(gen_b, b);
            drive_b(b, 1'b1, 1'b0, 1'b0, '{locked: (i == 21), bit_err: 1'b0, cnt: 16'd0});
        end
        for (int i = 0; i < 70000; i++) begin
            gen_step(gen_b, b);
            n = (i + 1 > 65535) ? 65535 : i + 1;
            drive_b(~b, 1'b1, 1'b0, 1'b0, '{locked: 1'b1, bit_err: 1'b1, cnt: 16'(n)});
        end
        total++;
        if (bus_b.o_Error_Count !== 16'hFFFF) begin
            bad++; $display("FAIL sat_hold got=%0h exp=ffff", bus_b.o_Error_Count);
        end
        total++;
        if (bus_b.o_Locked !== 1'b1) begin
            bad++; $display("FAIL sat_locked got=%0b exp=1", bus_b.o_Locked);
        end
        gen_step(gen_b, b);
        drive_b(~b, 1'b1, 1'b1, 1'b0, '{locked: 1'b1, bit_err: 1'b1, cnt: 16'd1});
        total++;
        if (bus_b.o_Error_Count !== 16'd1) begin
            bad++; $display("FAIL clear_with_error got=%0d exp=1", bus_b.o_Error_Count);
        end
        drive_b(1'b0, 1'b0, 1'b1, 1'b0, '{locked: 1'b1, bit_err: 1'b0, cnt: 16'd0});
        total++;
        if (bus_b.o_Error_Count !== 16'd0) begin
            bad++; $display("FAIL clear_alone got=%0d exp=0", bus_b.o_Error_Count);
        end
    endtask

    initial begin
        bus_a.i_Data  = 1'b0;
        bus_a.i_Valid = 1'b0;
        bus_a.i_Clear = 1'b0;
        bus_b.i_Data  = 1'b0;
        bus_b.i_Valid = 1'b0;
        bus_b.i_Clear = 1'b0;
        test_reset();
        test_lock();
        test_single_error();
        test_loss();
        test_lockup();
        test_back_to_back();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
